// File: rtl/framebuffer_reader.sv
// Streams a 4-bit-per-pixel frame out of the framebuffer as packed bytes
// {pixel(x+1), pixel(x)} to a UART transmitter, row-major, x ascending.
module framebuffer_reader #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic [9:0]  o_addr_x,
  output logic [9:0]  o_addr_y,
  output logic        o_read,
  input  logic [31:0] i_data_in,
  output logic [7:0]  o_data_out,
  output logic        o_tx_data_valid,
  input  logic        i_tx_busy,
  output logic        o_done_sending
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_EVEN   = 3'd1,
    ST_WAIT_EVEN = 3'd2,
    ST_RD_ODD    = 3'd3,
    ST_WAIT_ODD  = 3'd4,
    ST_SEND      = 3'd5,
    ST_ADVANCE   = 3'd6
  } state_t;

  // x of the last pixel pair in a line, and the last line of the frame
  localparam logic [9:0] LP_X_LAST = 10'(H_RES - 2);
  localparam logic [9:0] LP_Y_LAST = 10'(V_RES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic [9:0]  r_addr_x;
  logic [9:0]  r_addr_y;
  logic [9:0]  w_addr_x_nxt;
  logic [9:0]  w_addr_y_nxt;
  logic        r_read;
  logic        w_read_nxt;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_unused;

  assign w_unused = ^i_data_in[31:4];

  // Next-state, scan counters and next values for every registered output
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_addr_x_nxt = r_addr_x;
    w_addr_y_nxt = r_addr_y;
    w_read_nxt   = 1'b0;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_done_nxt   = r_done;
    case (r_state)
      ST_IDLE: begin
        w_x_nxt = 10'd0;
        w_y_nxt = 10'd0;
        if (i_start) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = ST_RD_EVEN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_EVEN:   w_state_nxt = ST_WAIT_EVEN;
      ST_WAIT_EVEN: begin
        w_data_nxt  = {r_data[7:4], i_data_in[3:0]};
        w_state_nxt = ST_RD_ODD;
      end
      ST_RD_ODD:    w_state_nxt = ST_WAIT_ODD;
      ST_WAIT_ODD: begin
        w_data_nxt  = {i_data_in[3:0], r_data[3:0]};
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_ADVANCE;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_ADVANCE: begin
        if (r_x == LP_X_LAST) begin
          w_x_nxt = 10'd0;
          if (r_y == LP_Y_LAST) begin
            w_y_nxt     = 10'd0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_y_nxt     = r_y + 10'd1;
            w_state_nxt = ST_RD_EVEN;
          end
        end else begin
          w_x_nxt     = r_x + 10'd2;
          w_state_nxt = ST_RD_EVEN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Read strobe and address are registered, so they are set on entry to a read state
    if (w_state_nxt == ST_RD_EVEN) begin
      w_read_nxt   = 1'b1;
      w_addr_x_nxt = w_x_nxt;
      w_addr_y_nxt = w_y_nxt;
    end else if (w_state_nxt == ST_RD_ODD) begin
      w_read_nxt   = 1'b1;
      w_addr_x_nxt = r_x + 10'd1;
      w_addr_y_nxt = r_y;
    end else begin
      w_read_nxt   = 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scan counters and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x      <= 10'd0;
      r_y      <= 10'd0;
      r_addr_x <= 10'd0;
      r_addr_y <= 10'd0;
      r_read   <= 1'b0;
      r_data   <= 8'd0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_addr_x <= w_addr_x_nxt;
      r_addr_y <= w_addr_y_nxt;
      r_read   <= w_read_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign o_addr_x        = r_addr_x;
  assign o_addr_y        = r_addr_y;
  assign o_read          = r_read;
  assign o_data_out      = r_data;
  assign o_tx_data_valid = r_valid;
  assign o_done_sending  = r_done;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Directed bench: a 4x2 frame for byte values, timing, backpressure and reset,
// plus a 640x8 frame with random RAM contents for line wrap at full width.
module tb_framebuffer_reader;

  localparam int W_H = 640;
  localparam int W_V = 8;
  localparam int W_BYTES = W_H * W_V / 2;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset = 1'b1;
  logic s_start = 1'b0;
  logic w_start = 1'b0;

  logic [9:0]  s_ax, s_ay, w_ax, w_ay;
  logic        s_rd, w_rd, s_vld, w_vld, s_done, w_done, s_busy;
  logic        w_busy = 1'b0;
  logic [31:0] s_din = 32'd0;
  logic [31:0] w_din = 32'd0;
  logic [7:0]  s_dout, w_dout;

  framebuffer_reader #(.H_RES(4), .V_RES(2)) u_small (
    .i_clk(clk), .i_reset(reset), .i_start(s_start),
    .o_addr_x(s_ax), .o_addr_y(s_ay), .o_read(s_rd), .i_data_in(s_din),
    .o_data_out(s_dout), .o_tx_data_valid(s_vld), .i_tx_busy(s_busy),
    .o_done_sending(s_done)
  );

  framebuffer_reader #(.H_RES(W_H), .V_RES(W_V)) u_wide (
    .i_clk(clk), .i_reset(reset), .i_start(w_start),
    .o_addr_x(w_ax), .o_addr_y(w_ay), .o_read(w_rd), .i_data_in(w_din),
    .o_data_out(w_dout), .o_tx_data_valid(w_vld), .i_tx_busy(w_busy),
    .o_done_sending(w_done)
  );

  int n_chk = 0;
  int n_err = 0;
  int s_cyc = 0;
  int s_rd_cnt = 0;
  int s_hold = 0;
  int s_busy_cnt = 0;
  logic s_vld_prev = 1'b0;
  logic [7:0] s_q[$];
  int         s_qc[$];
  logic [7:0] w_q[$];
  logic [3:0] w_ram [W_H*W_V];
  logic [7:0] exp_small [4] = '{8'h10, 8'h32, 8'h54, 8'h76};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h @cycle %0d", tag, got, exp, s_cyc);
    end
  endtask

  always @(posedge clk) s_cyc <= s_cyc + 1;

  // RAM models: one-cycle read latency, junk in the ignored upper bits
  always @(posedge clk) begin
    if (s_rd) s_din <= {28'($urandom), 4'(int'(s_ax) + 4 * int'(s_ay))};
    if (w_rd) w_din <= {28'($urandom), w_ram[int'(w_ay) * W_H + int'(w_ax)]};
  end

  // TX model: busy for s_hold cycles starting the cycle after each strobe
  always @(posedge clk) begin
    if (reset) s_busy_cnt <= 0;
    else if (s_busy_cnt != 0) s_busy_cnt <= s_busy_cnt - 1;
    else if (s_vld && s_hold != 0) s_busy_cnt <= s_hold;
  end
  assign s_busy = (s_busy_cnt != 0);

  // Byte monitors
  always @(negedge clk) begin
    if (s_rd) s_rd_cnt++;
    if (s_vld) begin
      s_q.push_back(s_dout);
      s_qc.push_back(s_cyc);
      check_value("valid_while_busy", 32'(s_busy), 32'd0);
      check_value("valid_back2back", 32'(s_vld_prev), 32'd0);
    end
    s_vld_prev = s_vld;
    if (w_vld) w_q.push_back(w_dout);
  end

  task automatic check_small_zero(input string tag);
    check_value({tag, "_addr_x"}, 32'(s_ax), 32'd0);
    check_value({tag, "_addr_y"}, 32'(s_ay), 32'd0);
    check_value({tag, "_read"}, 32'(s_rd), 32'd0);
    check_value({tag, "_data_out"}, 32'(s_dout), 32'd0);
    check_value({tag, "_valid"}, 32'(s_vld), 32'd0);
    check_value({tag, "_done"}, 32'(s_done), 32'd0);
  endtask

  task automatic run_small(input int hold, input bit mid_start);
    int n;
    s_q.delete();
    s_qc.delete();
    s_hold = hold;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    if (mid_start) begin
      repeat (3) @(negedge clk);
      s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
    end
    n = 0;
    while (!s_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_value("small_done", 32'(s_done), 32'd1);
    repeat (20) @(negedge clk);
    check_value("small_done_held", 32'(s_done), 32'd1);
    check_value("small_byte_count", 32'(s_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < s_q.size()) check_value("small_byte", 32'(s_q[i]), 32'(exp_small[i]));
    if (hold == 0)
      for (int i = 1; i < s_qc.size(); i++)
        check_value("small_gap", 32'(s_qc[i] - s_qc[i-1]), 32'd6);
    n = 0;
    while (s_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int k;
    for (int i = 0; i < W_H * W_V; i++) w_ram[i] = 4'($urandom);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_small_zero("reset");
    check_value("reset_wide_read", 32'(w_rd), 32'd0);
    reset = 1'b0;
    s_rd_cnt = 0;
    repeat (100) @(negedge clk);
    check_value("idle_reads", 32'(s_rd_cnt), 32'd0);
    check_value("idle_bytes", 32'(s_q.size()), 32'd0);

    run_small(0, 1'b0);
    run_small(0, 1'b1);
    run_small(200, 1'b0);

    // Reset on the cycle after the second byte
    s_q.delete();
    s_hold = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    k = 0;
    n = 0;
    while (k < 2 && n < 500) begin
      if (s_vld) k++;
      if (k < 2) @(negedge clk);
      n++;
    end
    check_value("second_byte_seen", 32'(k), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_small_zero("midreset");
    s_rd_cnt = 0;
    repeat (100) @(negedge clk);
    check_value("midreset_bytes", 32'(s_q.size()), 32'd2);
    check_value("midreset_reads", 32'(s_rd_cnt), 32'd0);
    run_small(0, 1'b0);

    // Full-width frame with random contents
    w_q.delete();
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    n = 0;
    while (!w_done && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check_value("wide_done", 32'(w_done), 32'd1);
    check_value("wide_byte_count", 32'(w_q.size()), 32'(W_BYTES));
    for (int i = 0; i < W_BYTES; i++) begin
      if (i < w_q.size()) begin
        int base;
        base = (i / (W_H / 2)) * W_H + (i % (W_H / 2)) * 2;
        check_value("wide_byte", 32'(w_q[i]), 32'({w_ram[base + 1], w_ram[base]}));
      end
    end
    check_value("wide_last_addr_x", 32'(w_ax), 32'(W_H - 1));
    check_value("wide_last_addr_y", 32'(w_ay), 32'(W_V - 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
